// File: rtl/z88_pkg.sv
// Shared types and constants for the Z88 memory-slot controller.
package z88_pkg;

  localparam int unsigned NUM_SLOTS_DEF = 5;
  localparam int unsigned ADDR_W_DEF    = 22;
  localparam int unsigned MEM_AW_DEF    = 20;
  localparam int unsigned WAIT_W_DEF    = 3;
  localparam int unsigned DATA_W        = 8;

  localparam int unsigned SLOT_ROM   = 0;
  localparam int unsigned SLOT_RAM   = 1;
  localparam int unsigned SLOT_CARD1 = 2;
  localparam int unsigned SLOT_CARD2 = 3;
  localparam int unsigned SLOT_CARD3 = 4;

  localparam logic [DATA_W-1:0] RDATA_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/z88_slot_ctrl_if.sv
// Blink-side request bus plus memory-side strobes of the slot controller.
interface z88_slot_ctrl_if #(
  parameter int unsigned NUM_SLOTS = z88_pkg::NUM_SLOTS_DEF,
  parameter int unsigned ADDR_W    = z88_pkg::ADDR_W_DEF,
  parameter int unsigned MEM_AW    = z88_pkg::MEM_AW_DEF,
  parameter int unsigned WAIT_W    = z88_pkg::WAIT_W_DEF
) ();

  logic [NUM_SLOTS-1:0]        sel_n;
  logic [ADDR_W-1:0]           ma;
  logic                        roe_n;
  logic                        wrb_n;
  logic [7:0]                  wdata;
  logic [NUM_SLOTS*WAIT_W-1:0] wait_cfg;
  logic [NUM_SLOTS-1:0]        wp;
  logic [NUM_SLOTS*8-1:0]      mem_do;

  logic [MEM_AW-1:0]           mem_a;
  logic [7:0]                  mem_di;
  logic [NUM_SLOTS-1:0]        mem_ce_n;
  logic                        mem_oe_n;
  logic                        mem_we_n;
  logic [7:0]                  rdata;
  logic                        wait_n;
  logic                        wp_hit;
  logic                        sel_err;

  modport master (
    output sel_n, ma, roe_n, wrb_n, wdata, wait_cfg, wp, mem_do,
    input  mem_a, mem_di, mem_ce_n, mem_oe_n, mem_we_n, rdata, wait_n, wp_hit, sel_err
  );

  modport slave (
    input  sel_n, ma, roe_n, wrb_n, wdata, wait_cfg, wp, mem_do,
    output mem_a, mem_di, mem_ce_n, mem_oe_n, mem_we_n, rdata, wait_n, wp_hit, sel_err
  );

endinterface

// File: rtl/z88_slot_prio.sv
// Lowest-index priority encoder over active-high slot selects.
module z88_slot_prio #(
  parameter int unsigned N  = 5,
  parameter int unsigned SW = 3
) (
  input  logic [N-1:0]  i_sel,
  output logic [SW-1:0] o_slot_c,
  output logic          o_any_c,
  output logic          o_multi_c
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    o_slot_c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_sel[i]) o_slot_c = SW'(i);
    end
  end

  assign o_any_c   = |i_sel;
  assign o_multi_c = |(i_sel & (i_sel - N'(1)));

endmodule

// File: rtl/z88_slot_ctrl.sv
// Per-slot wait-state engine: strobes one memory, stretches Z80 wait_n,
// registers read data and blocks writes to protected slots.
module z88_slot_ctrl
  import z88_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MEM_AW    = MEM_AW_DEF,
  parameter int unsigned WAIT_W    = WAIT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  z88_slot_ctrl_if.slave bus
);

  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  state_t               r_state, w_state_nxt;
  logic [SLOT_W-1:0]    r_slot, w_slot_nxt;
  logic                 r_rd, w_rd_nxt;
  logic                 r_blk, w_blk_nxt;
  logic [WAIT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_SLOTS-1:0] r_ce_n, w_ce_n_nxt;
  logic                 r_oe_n, w_oe_n_nxt;
  logic                 r_we_n, w_we_n_nxt;
  logic [MEM_AW-1:0]    r_a, w_a_nxt;
  logic [7:0]           r_di, w_di_nxt;
  logic [7:0]           r_rdata, w_rdata_nxt;
  logic                 r_wp_hit, w_wp_hit_nxt;
  logic                 r_sel_err, w_sel_err_nxt;

  logic [SLOT_W-1:0]    w_slot;
  logic                 w_any, w_multi, w_rd, w_wr, w_req;
  logic [WAIT_W-1:0]    w_cfg_sel;
  logic                 w_wp_sel;
  logic [7:0]           w_do_sel;
  logic                 w_unused_ma;

  assign w_rd        = ~bus.roe_n;
  assign w_wr        = ~bus.wrb_n;
  assign w_req       = w_any & (w_rd | w_wr);
  assign w_unused_ma = ^bus.ma[ADDR_W-1:MEM_AW];

  z88_slot_prio #(
    .N  (NUM_SLOTS),
    .SW (SLOT_W)
  ) u_prio (
    .i_sel     (~bus.sel_n),
    .o_slot_c  (w_slot),
    .o_any_c   (w_any),
    .o_multi_c (w_multi)
  );

  // Per-slot config for the requesting slot, read data for the latched slot.
  always_comb begin
    w_cfg_sel = '0;
    w_wp_sel  = 1'b0;
    w_do_sel  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_slot == SLOT_W'(i)) begin
        w_cfg_sel = bus.wait_cfg[i*WAIT_W +: WAIT_W];
        w_wp_sel  = bus.wp[i];
      end
      if (r_slot == SLOT_W'(i)) w_do_sel = bus.mem_do[i*8 +: 8];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_rd_nxt      = r_rd;
    w_blk_nxt     = r_blk;
    w_cnt_nxt     = r_cnt;
    w_ce_n_nxt    = r_ce_n;
    w_oe_n_nxt    = r_oe_n;
    w_we_n_nxt    = r_we_n;
    w_a_nxt       = r_a;
    w_di_nxt      = r_di;
    w_rdata_nxt   = r_rdata;
    w_wp_hit_nxt  = 1'b0;
    w_sel_err_nxt = r_sel_err;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_STROBE;
          w_slot_nxt  = w_slot;
          w_rd_nxt    = w_rd;
          w_blk_nxt   = ~w_rd & w_wp_sel;
          w_cnt_nxt   = w_cfg_sel;
          w_a_nxt     = bus.ma[MEM_AW-1:0];
          w_di_nxt    = bus.wdata;
          w_ce_n_nxt  = ~(NUM_SLOTS'(1) << w_slot);
          w_oe_n_nxt  = ~w_rd;
          w_we_n_nxt  = w_rd | w_wp_sel;
          if (w_multi) w_sel_err_nxt = 1'b1;
        end
      end
      // The count always runs to completion, even if the request is withdrawn.
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt  = ST_HOLD;
          w_ce_n_nxt   = '1;
          w_oe_n_nxt   = 1'b1;
          w_we_n_nxt   = 1'b1;
          w_wp_hit_nxt = r_blk;
          if (r_rd) w_rdata_nxt = w_do_sel;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!w_req) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_rd      <= 1'b0;
      r_blk     <= 1'b0;
      r_cnt     <= '0;
      r_ce_n    <= '1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_a       <= '0;
      r_di      <= '0;
      r_rdata   <= RDATA_IDLE;
      r_wp_hit  <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_rd      <= w_rd_nxt;
      r_blk     <= w_blk_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_a       <= w_a_nxt;
      r_di      <= w_di_nxt;
      r_rdata   <= w_rdata_nxt;
      r_wp_hit  <= w_wp_hit_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  // wait_n drops in the request cycle itself, before the FSM has moved.
  assign bus.wait_n   = reset | ~(((r_state == ST_IDLE) & w_req) | (r_state == ST_STROBE));
  assign bus.mem_a    = r_a;
  assign bus.mem_di   = r_di;
  assign bus.mem_ce_n = r_ce_n;
  assign bus.mem_oe_n = r_oe_n;
  assign bus.mem_we_n = r_we_n;
  assign bus.rdata    = r_rdata;
  assign bus.wp_hit   = r_wp_hit;
  assign bus.sel_err  = r_sel_err;

endmodule

// File: tb/tb_z88_slot_ctrl.sv
// Transaction-level bench for z88_slot_ctrl: directed cases then random traffic.
module tb_z88_slot_ctrl;
  import z88_pkg::*;

  localparam int unsigned NS    = 5;
  localparam int unsigned AW    = 22;
  localparam int unsigned MAW   = 20;
  localparam int unsigned WW    = 3;
  localparam int unsigned CFG_W = NS * WW;
  localparam int unsigned MDW   = NS * 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z88_slot_ctrl_if #(.NUM_SLOTS(NS), .ADDR_W(AW), .MEM_AW(MAW), .WAIT_W(WW)) bus ();

  z88_slot_ctrl #(.NUM_SLOTS(NS), .ADDR_W(AW), .MEM_AW(MAW), .WAIT_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_rdata;
  logic       m_sel_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_bus();
    bus.sel_n = '1;
    bus.roe_n = 1'b1;
    bus.wrb_n = 1'b1;
  endtask

  // op: 0 read, 1 write, 2 both strobes low (treated as read). Called at a negedge.
  task automatic run_txn(input logic [NS-1:0] sel, input int op, input logic [AW-1:0] ma,
                         input logic [7:0] wd, input logic [CFG_W-1:0] cfg,
                         input logic [NS-1:0] wpv, input logic [MDW-1:0] mdo,
                         input bit abort, input int hold);
    int slot, nsel, n, c, wlow, ce_act, ce_bad, oe_low, we_low, hit;
    bit rd, blk, done;
    logic [7:0]    prev_rdata;
    logic [NS-1:0] exp_ce;
    slot = 0;
    nsel = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!sel[i]) begin
        slot = i;
        nsel++;
      end
    end
    n          = int'(cfg[slot*WW +: WW]);
    rd         = (op != 1);
    blk        = !rd && wpv[slot];
    exp_ce     = ~(NS'(1) << slot);
    prev_rdata = m_rdata;
    if (rd) m_rdata = mdo[slot*8 +: 8];
    if (nsel > 1) m_sel_err = 1'b1;

    bus.sel_n    = sel;
    bus.roe_n    = (op == 1);
    bus.wrb_n    = (op == 0);
    bus.ma       = ma;
    bus.wdata    = wd;
    bus.wait_cfg = cfg;
    bus.wp       = wpv;
    bus.mem_do   = mdo;

    c = 0; wlow = 0; ce_act = 0; ce_bad = 0; oe_low = 0; we_low = 0; hit = 0; done = 0;
    while (!done) begin
      #1;
      if (!bus.wait_n) wlow++;
      if (bus.mem_ce_n !== '1) begin
        ce_act++;
        if (bus.mem_ce_n !== exp_ce) ce_bad++;
      end
      if (!bus.mem_oe_n) oe_low++;
      if (!bus.mem_we_n) we_low++;
      if (bus.wp_hit)    hit++;
      if (c == n + 1) check_eq("rdata_before", 32'(bus.rdata), 32'(prev_rdata));
      if (c == n + 2) begin
        check_eq("rdata", 32'(bus.rdata), 32'(m_rdata));
        check_eq("mem_a", 32'(bus.mem_a), 32'(ma[MAW-1:0]));
        check_eq("mem_di", 32'(bus.mem_di), 32'(wd));
        check_eq("sel_err", 32'(bus.sel_err), 32'(m_sel_err));
      end
      if (c == 1) begin
        bus.wait_cfg = CFG_W'($urandom);
        if (abort) idle_bus();
      end
      if (c == n + 2 + hold) idle_bus();
      if (c == n + 4 + hold) done = 1;
      c++;
      @(negedge clk);
    end
    check_eq("wait_low_cycles", 32'(wlow), 32'(n + 2));
    check_eq("ce_cycles", 32'(ce_act), 32'(n + 1));
    check_eq("ce_onehot", 32'(ce_bad), 32'd0);
    check_eq("oe_cycles", 32'(oe_low), rd ? 32'(n + 1) : 32'd0);
    check_eq("we_cycles", 32'(we_low), (!rd && !blk) ? 32'(n + 1) : 32'd0);
    check_eq("wp_hit_cycles", 32'(hit), blk ? 32'd1 : 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_ce"}, 32'(bus.mem_ce_n), 32'(NS'('1)));
    check_eq({tag, "_oe"}, 32'(bus.mem_oe_n), 32'd1);
    check_eq({tag, "_we"}, 32'(bus.mem_we_n), 32'd1);
    check_eq({tag, "_rdata"}, 32'(bus.rdata), 32'hFF);
    check_eq({tag, "_wait"}, 32'(bus.wait_n), 32'd1);
    check_eq({tag, "_wphit"}, 32'(bus.wp_hit), 32'd0);
    check_eq({tag, "_selerr"}, 32'(bus.sel_err), 32'd0);
  endtask

  initial begin
    logic [NS-1:0]    sel;
    logic [CFG_W-1:0] cfg;
    logic [MDW-1:0]   mdo;
    reset        = 1'b1;
    idle_bus();
    bus.ma       = '0;
    bus.wdata    = '0;
    bus.wait_cfg = '0;
    bus.wp       = '0;
    bus.mem_do   = '0;
    m_rdata      = 8'hFF;
    m_sel_err    = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    check_eq("reset_mem_a", 32'(bus.mem_a), 32'd0);
    check_eq("reset_mem_di", 32'(bus.mem_di), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read slot 1, no wait states.
    run_txn(5'b11101, 0, 22'h00_0010, 8'h00, CFG_W'(0), 5'b00000, MDW'(40'h00_00_00_A5_00), 0, 0);
    // Read slot 2, three wait states.
    run_txn(5'b11011, 0, 22'h00_0020, 8'h00, CFG_W'(3 << 6), 5'b00000, MDW'(40'h00_00_3C_00_00), 0, 1);
    // Write slot 1, one wait state.
    run_txn(5'b11101, 1, 22'h04_1234, 8'h77, CFG_W'(1 << 3), 5'b00000, MDW'(0), 0, 0);
    // Write to protected ROM slot.
    run_txn(5'b11110, 1, 22'h00_0ABC, 8'h11, CFG_W'(2), 5'b00001, MDW'(0), 0, 0);
    // Multi-select read resolves to slot 0 and latches sel_err.
    run_txn(5'b11100, 0, 22'h00_0001, 8'h00, CFG_W'(1), 5'b00000, MDW'(40'h00_00_00_00_5A), 0, 0);
    run_txn(5'b10111, 2, 22'h3F_FFFF, 8'h22, CFG_W'(4 << 9), 5'b00000, MDW'(40'h00_C3_00_00_00), 0, 2);

    // Reset in the middle of a long write.
    bus.sel_n    = 5'b11101;
    bus.roe_n    = 1'b1;
    bus.wrb_n    = 1'b0;
    bus.wdata    = 8'h99;
    bus.wait_cfg = CFG_W'(7 << 3);
    bus.wp       = '0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_we", 32'(bus.mem_we_n), 32'd0);
    #1 reset = 1'b1;
    #1 reset_checks("midreset");
    idle_bus();
    m_rdata   = 8'hFF;
    m_sel_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_txn(5'b01111, 0, 22'h12_3456, 8'h00, CFG_W'(2 << 12), 5'b00000, MDW'(40'h E7_00_00_00_00), 0, 0);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(4, 0) != 0) begin
        sel = ~(NS'(1) << $urandom_range(NS - 1, 0));
      end else begin
        sel = NS'($urandom);
        if (sel == '1) sel[$urandom_range(NS - 1, 0)] = 1'b0;
      end
      cfg = CFG_W'($urandom);
      mdo = MDW'({$urandom, $urandom});
      run_txn(sel, int'($urandom_range(2, 0)), AW'($urandom), 8'($urandom), cfg,
              NS'($urandom), mdo, ($urandom_range(4, 0) == 0), int'($urandom_range(3, 0)));
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
